// File: rtl/chdr_conv_arbiter_if.sv
// Stream side of the CHDR converter arbiter: NUM_PORTS input streams in, one
// stream out to the shared converter, tagged with the granted port index.
interface chdr_conv_arbiter_if #(
  parameter int NUM_PORTS = 4
);
  logic [64*NUM_PORTS-1:0] i_tdata;
  logic [NUM_PORTS-1:0]    i_tlast;
  logic [NUM_PORTS-1:0]    i_tvalid;
  logic [NUM_PORTS-1:0]    i_tready;
  logic [63:0]             o_tdata;
  logic                    o_tlast;
  logic                    o_tvalid;
  logic                    o_tready;
  logic [2:0]              o_port;

  modport slave (
    input  i_tdata, i_tlast, i_tvalid, o_tready,
    output i_tready, o_tdata, o_tlast, o_tvalid, o_port
  );

  modport master (
    output i_tdata, i_tlast, i_tvalid, o_tready,
    input  i_tready, o_tdata, o_tlast, o_tvalid, o_port
  );
endinterface

// File: rtl/chdr_conv_arbiter.sv
// Packet-locked arbiter sharing one CHDR 16->8 sample converter between
// NUM_PORTS input streams; round-robin or fixed priority, per-port enable mask.

// One input port's slice of the output mux and its ready gate.
module chdr_conv_arbiter_lane (
  input  logic        sel,
  input  logic [63:0] tdata,
  input  logic        tlast,
  input  logic        tvalid,
  input  logic        o_tready,
  output logic [63:0] m_tdata,
  output logic        m_tlast,
  output logic        m_tvalid,
  output logic        tready
);
  assign m_tdata  = {64{sel}} & tdata;
  assign m_tlast  = sel & tlast;
  assign m_tvalid = sel & tvalid;
  assign tready   = sel & o_tready;
endmodule

module chdr_conv_arbiter #(
  parameter int         NUM_PORTS = 4,
  parameter logic [7:0] BASE      = 8'd0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  chdr_conv_arbiter_if.slave   s,
  input  logic                 set_stb,
  input  logic [7:0]           set_addr,
  input  logic [31:0]          set_data,
  output logic [15:0]          pkt_count,
  output logic                 busy
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PASS = 1'b1;

  logic [0:0]           state;
  logic [NUM_PORTS-1:0] mask;
  logic                 mode;
  logic [2:0]           ptr;
  logic [2:0]           grant;
  logic [NUM_PORTS-1:0] req;
  logic [2:0]           pick;
  logic                 pick_vld;
  logic                 cfg_unused;

  logic [NUM_PORTS-1:0][63:0] lane_tdata;
  logic [NUM_PORTS-1:0]       lane_tlast;
  logic [NUM_PORTS-1:0]       lane_tvalid;
  logic [NUM_PORTS-1:0]       lane_tready;
  logic [NUM_PORTS-1:0]       sel;

  assign cfg_unused = ^set_data;
  assign req        = s.i_tvalid & mask;

  // Descending sweeps so the last hit is the winner: lowest index in fixed
  // mode, smallest distance above the pointer in round-robin mode.
  always_comb begin
    pick     = '0;
    pick_vld = |req;
    if (mode) begin
      for (int i = NUM_PORTS - 1; i >= 0; i--)
        if (req[i]) pick = 3'(i);
    end else begin
      for (int off = NUM_PORTS; off >= 1; off--)
        for (int i = 0; i < NUM_PORTS; i++)
          if (req[i] && ((int'(ptr) + off) % NUM_PORTS) == i) pick = 3'(i);
    end
  end

  generate
    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_lane
      assign sel[k] = (state == PASS) && (grant == 3'(k));
      chdr_conv_arbiter_lane u_lane (
        .sel      (sel[k]),
        .tdata    (s.i_tdata[64*k +: 64]),
        .tlast    (s.i_tlast[k]),
        .tvalid   (s.i_tvalid[k]),
        .o_tready (s.o_tready),
        .m_tdata  (lane_tdata[k]),
        .m_tlast  (lane_tlast[k]),
        .m_tvalid (lane_tvalid[k]),
        .tready   (lane_tready[k])
      );
    end
  endgenerate

  // At most one lane is selected, so OR-combining the lanes forms the mux.
  always_comb begin
    s.o_tdata = '0;
    for (int k = 0; k < NUM_PORTS; k++) s.o_tdata = s.o_tdata | lane_tdata[k];
  end

  assign s.o_tlast  = |lane_tlast;
  assign s.o_tvalid = |lane_tvalid;
  assign s.i_tready = lane_tready;
  assign s.o_port   = grant;
  assign busy       = (state == PASS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant     <= '0;
      ptr       <= 3'(NUM_PORTS - 1);
      pkt_count <= '0;
      mask      <= '1;
      mode      <= 1'b0;
    end else begin
      if (set_stb && set_addr == BASE) begin
        mask <= set_data[NUM_PORTS-1:0];
        mode <= set_data[8];
      end
      case (state)
        IDLE: if (pick_vld) begin
          grant <= pick;
          state <= PASS;
        end
        PASS: if (s.o_tvalid && s.o_tready && s.o_tlast) begin
          ptr       <= grant;
          pkt_count <= pkt_count + 16'd1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
